// File: rtl/mult_secuencial.sv
// Sequential unsigned shift-add multiplier: ANCHO x ANCHO -> 2*ANCHO product, one-cycle listo pulse.
// Optional early termination when the remaining multiplier bits are zero: define MULT_TERMINA_TEMPRANO_EN.
module mult_secuencial #(
  parameter int ANCHO = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [ANCHO-1:0]   operando_a,
  input  logic [ANCHO-1:0]   operando_b,
  output logic [2*ANCHO-1:0] producto,
  output logic               listo,
  output logic               ocupado
);

  localparam int CW = $clog2(ANCHO + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } estado_t;

  estado_t            estado;
  estado_t            estado_sig;
  logic [2*ANCHO-1:0] acumulador;
  logic [2*ANCHO-1:0] multiplicando;
  logic [ANCHO-1:0]   multiplicador;
  logic [CW-1:0]      contador;
  logic               ultimo_paso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig  = estado;
`ifdef MULT_TERMINA_TEMPRANO_EN
    // Done once the multiplier bits left after this shift are all zero.
    ultimo_paso = (contador == CW'(ANCHO - 1)) || (multiplicador[ANCHO-1:1] == '0);
`else
    ultimo_paso = (contador == CW'(ANCHO - 1));
`endif
    case (estado)
      IDLE: begin
        if (inicio) begin
`ifdef MULT_TERMINA_TEMPRANO_EN
          estado_sig = (operando_b == '0) ? FIN : CALC;
`else
          estado_sig = CALC;
`endif
        end
      end
      CALC:    if (ultimo_paso) estado_sig = FIN;
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  assign ocupado = (estado != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      producto      <= '0;
      listo         <= 1'b0;
      acumulador    <= '0;
      multiplicando <= '0;
      multiplicador <= '0;
      contador      <= '0;
    end else begin
      listo <= 1'b0;
      case (estado)
        IDLE: begin
          if (inicio) begin
            multiplicando <= {{ANCHO{1'b0}}, operando_a};
            multiplicador <= operando_b;
            acumulador    <= '0;
            contador      <= '0;
          end
        end
        CALC: begin
          if (multiplicador[0]) acumulador <= acumulador + multiplicando;
          multiplicando <= multiplicando << 1;
          multiplicador <= multiplicador >> 1;
          contador      <= contador + 1'b1;
        end
        FIN: begin
          producto <= acumulador;
          listo    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_secuencial.sv
// Directed self-checking bench for mult_secuencial (ANCHO=8); expected latency follows MULT_TERMINA_TEMPRANO_EN.
module tb_mult_secuencial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inicio = 1'b0;
  logic [7:0]  operando_a = '0;
  logic [7:0]  operando_b = '0;
  logic [15:0] producto;
  logic        listo;
  logic        ocupado;

  int errors = 0;
  int checks = 0;

  mult_secuencial #(.ANCHO(8)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio),
    .operando_a(operando_a), .operando_b(operando_b),
    .producto(producto), .listo(listo), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Edges after the accepting edge until listo is visible.
  function automatic int n_after(input logic [7:0] b);
`ifdef MULT_TERMINA_TEMPRANO_EN
    int m = 0;
    for (int i = 0; i < 8; i++) if (b[i]) m = i + 1;
    return (m == 0) ? 1 : m + 1;
`else
    return 9;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p, input string tag);
    int n;
    int busy;
    operando_a = a;
    operando_b = b;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    n = 0;
    busy = 0;
    while (!listo && n < 40) begin
      if (ocupado) busy++;
      step();
      n++;
    end
    check({tag, "_latency"}, n, n_after(b));
    check({tag, "_producto"}, producto, exp_p);
    check({tag, "_ocupado_cycles"}, busy, n_after(b));
    step();
    check({tag, "_listo_one_cycle"}, listo, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;

    #2;
    check("reset_producto", producto, 16'd0);
    check("reset_listo", listo, 1'b0);
    check("reset_ocupado", ocupado, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    run_op(8'd99, 8'd99, 16'd9801, "op_99x99");
    run_op(8'd0, 8'd57, 16'd0, "op_0x57");
    run_op(8'd57, 8'd0, 16'd0, "op_57x0");
    run_op(8'd255, 8'd255, 16'd65025, "op_255x255");

    // Requests and operand changes during CALC must be ignored.
    operando_a = 8'd12;
    operando_b = 8'd10;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    step(); step(); step();
    inicio = 1'b1;
    operando_a = 8'd3;
    operando_b = 8'd3;
    step();
    inicio = 1'b0;
    operando_a = 8'd77;
    n = 4;
    while (!listo && n < 40) begin
      step();
      n++;
    end
    check("midop_latency", n, n_after(8'd10));
    check("midop_producto", producto, 16'd120);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (listo) pulses++;
    end
    check("midop_no_second_listo", pulses, 0);

    // Async reset in the middle of an operation.
    operando_a = 8'd50;
    operando_b = 8'd50;
    inicio = 1'b1;
    step();
    inicio = 1'b0;
    step(); step(); step();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_producto", producto, 16'd0);
    check("rst_mid_listo", listo, 1'b0);
    check("rst_mid_ocupado", ocupado, 1'b0);
    step(); step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (listo) pulses++;
    end
    check("rst_mid_no_listo", pulses, 0);
    check("rst_mid_idle", ocupado, 1'b0);
    run_op(8'd7, 8'd6, 16'd42, "op_7x6");

    // inicio held high: back-to-back operations.
    operando_a = 8'd2;
    operando_b = 8'd3;
    inicio = 1'b1;
    step();
    n = 0;
    while (!listo && n < 40) begin
      step();
      n++;
    end
    check("b2b_first_latency", n, n_after(8'd3));
    for (int k = 0; k < 3; k++) begin
      step();
      check("b2b_accept_on_listo", ocupado, 1'b1);
      n = 1;
      while (!listo && n < 40) begin
        step();
        n++;
      end
      check("b2b_period", n, n_after(8'd3) + 1);
      check("b2b_producto", producto, 16'd6);
    end
    inicio = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("final_idle", ocupado, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
